// File: rtl/ft_alu_seq.sv
// Fault-tolerant sequencer around an external dual-rail ALU: it latches the operands, lets them settle,
// cross-checks both result rails and re-executes on mismatch, up to MAX_RETRY times.
module ft_alu_seq #(
    parameter int SETTLE    = 1,
    parameter int MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [2:0] req_a,
    input  logic [2:0] req_b,
    input  logic       req_par,
    input  logic [2:0] req_op,
    output logic [2:0] alu_a,
    output logic [2:0] alu_b,
    output logic       alu_par,
    output logic [2:0] alu_c,
    input  logic [2:0] alu_x,
    input  logic       alu_xc,
    input  logic [1:0] alu_xe,
    input  logic [2:0] alu_y,
    input  logic       alu_yc,
    input  logic [1:0] alu_ye,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [2:0] rsp_sum,
    output logic       rsp_cout,
    output logic [1:0] rsp_status,
    output logic [7:0] err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_RETRY = 2'b01;
    localparam logic [1:0] ST_INPUT = 2'b10;
    localparam logic [1:0] ST_HARD  = 2'b11;

    state_t     state_q, state_d;
    logic [3:0] settle_q, settle_d;
    logic [2:0] retry_q, retry_d;
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [2:0] alu_a_q, alu_a_d;
    logic [2:0] alu_b_q, alu_b_d;
    logic       alu_par_q, alu_par_d;
    logic [2:0] alu_c_q, alu_c_d;
    logic [2:0] rsp_sum_q, rsp_sum_d;
    logic       rsp_cout_q, rsp_cout_d;
    logic [1:0] rsp_status_q, rsp_status_d;

    logic       op_onehot;
    logic       in_ok;
    logic       chk_pass;
    logic [7:0] err_inc;

    always_comb begin
        op_onehot = (req_op == 3'b001) || (req_op == 3'b010) || (req_op == 3'b100);
        // Odd parity across both operands and the parity bit marks a clean transfer.
        in_ok     = op_onehot && (^{req_a, req_b, req_par});
        chk_pass  = (alu_xe == 2'b10) && (alu_ye == 2'b10) &&
                    ({alu_xc, alu_x} == {alu_yc, alu_y});
        err_inc   = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
    end

    always_comb begin
        state_d      = state_q;
        settle_d     = settle_q;
        retry_d      = retry_q;
        err_cnt_d    = err_cnt_q;
        alu_a_d      = alu_a_q;
        alu_b_d      = alu_b_q;
        alu_par_d    = alu_par_q;
        alu_c_d      = alu_c_q;
        rsp_sum_d    = rsp_sum_q;
        rsp_cout_d   = rsp_cout_q;
        rsp_status_d = rsp_status_q;

        unique case (state_q)
            IDLE: begin
                alu_c_d = 3'b000;
                if (req_valid) begin
                    alu_a_d   = req_a;
                    alu_b_d   = req_b;
                    alu_par_d = req_par;
                    retry_d   = 3'd0;
                    if (in_ok) begin
                        alu_c_d  = req_op;
                        settle_d = SETTLE_LOAD;
                        state_d  = DRIVE;
                    end else begin
                        rsp_sum_d    = 3'd0;
                        rsp_cout_d   = 1'b0;
                        rsp_status_d = ST_INPUT;
                        state_d      = RESP;
                    end
                end
            end
            DRIVE: begin
                if (settle_q == 4'd0) begin
                    state_d = CHECK;
                end else begin
                    settle_d = settle_q - 4'd1;
                end
            end
            CHECK: begin
                if (chk_pass) begin
                    rsp_sum_d    = alu_x;
                    rsp_cout_d   = alu_xc;
                    rsp_status_d = (retry_q == 3'd0) ? ST_OK : ST_RETRY;
                    state_d      = RESP;
                end else begin
                    err_cnt_d = err_inc;
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d  = retry_q + 3'd1;
                        settle_d = SETTLE_LOAD;
                        state_d  = DRIVE;
                    end else begin
                        rsp_sum_d    = alu_x;
                        rsp_cout_d   = alu_xc;
                        rsp_status_d = ST_HARD;
                        state_d      = RESP;
                    end
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    alu_c_d = 3'b000;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            settle_q     <= 4'd0;
            retry_q      <= 3'd0;
            err_cnt_q    <= 8'd0;
            alu_a_q      <= 3'd0;
            alu_b_q      <= 3'd0;
            alu_par_q    <= 1'b0;
            alu_c_q      <= 3'b000;
            rsp_sum_q    <= 3'd0;
            rsp_cout_q   <= 1'b0;
            rsp_status_q <= 2'b00;
        end else begin
            state_q      <= state_d;
            settle_q     <= settle_d;
            retry_q      <= retry_d;
            err_cnt_q    <= err_cnt_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_par_q    <= alu_par_d;
            alu_c_q      <= alu_c_d;
            rsp_sum_q    <= rsp_sum_d;
            rsp_cout_q   <= rsp_cout_d;
            rsp_status_q <= rsp_status_d;
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign rsp_valid  = (state_q == RESP);
    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_par    = alu_par_q;
    assign alu_c      = alu_c_q;
    assign rsp_sum    = rsp_sum_q;
    assign rsp_cout   = rsp_cout_q;
    assign rsp_status = rsp_status_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ft_alu_seq.sv
// Bench for ft_alu_seq: a dual-rail ALU model with cycle-scheduled fault injection drives the DUT,
// and every response is compared with an outcome derived from the request and the fault plan.
module tb_ft_alu_seq;

    localparam int SETTLE    = 1;
    localparam int MAX_RETRY = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_a, req_b, req_op;
    logic       req_par;
    logic [2:0] alu_a, alu_b, alu_c;
    logic       alu_par;
    logic [2:0] alu_x, alu_y;
    logic       alu_xc, alu_yc;
    logic [1:0] alu_xe, alu_ye;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [2:0] rsp_sum;
    logic       rsp_cout;
    logic [1:0] rsp_status;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;
    int err_exp  = 0;

    // Fault plan: attempts with index < nfail_cur see the fault of type kind_cur.
    bit fault_en  = 0;
    int cur_cyc   = 0;
    int nfail_cur = 0;
    int kind_cur  = 0;
    bit fault_act;

    always #5 clk = ~clk;

    ft_alu_seq #(.SETTLE(SETTLE), .MAX_RETRY(MAX_RETRY)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_par(req_par), .req_op(req_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_par(alu_par), .alu_c(alu_c),
        .alu_x(alu_x), .alu_xc(alu_xc), .alu_xe(alu_xe),
        .alu_y(alu_y), .alu_yc(alu_yc), .alu_ye(alu_ye),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_sum(rsp_sum), .rsp_cout(rsp_cout), .rsp_status(rsp_status),
        .err_cnt(err_cnt)
    );

    // Dual-rail ALU model; both rails agree unless a fault is active.
    logic [3:0] alu_g;
    always_comb begin
        fault_act = fault_en && (cur_cyc >= 1) && (((cur_cyc - 1) / (SETTLE + 1)) < nfail_cur);
        case (alu_c)
            3'b001:  alu_g = {1'b0, alu_a} + {1'b0, alu_b};
            3'b010:  alu_g = {1'b0, alu_a} + {1'b0, ~alu_b} + 4'd1;
            3'b100:  alu_g = {1'b0, alu_b} + {1'b0, ~alu_a} + 4'd1;
            default: alu_g = 4'd0;
        endcase
        alu_x  = alu_g[2:0];
        alu_xc = alu_g[3];
        alu_xe = 2'b10;
        alu_y  = alu_g[2:0];
        alu_yc = alu_g[3];
        alu_ye = 2'b10;
        if (fault_act) begin
            case (kind_cur)
                0:       alu_xe = 2'b11;
                1:       alu_y  = alu_g[2:0] ^ 3'b001;
                2:       alu_ye = 2'b00;
                default: alu_x  = alu_g[2:0] ^ 3'b010;
            endcase
        end
    end

    typedef struct {
        int         lat;
        logic [2:0] sum;
        logic       cout;
        logic [1:0] st;
        int         fails;
    } exp_t;

    // Expected outcome from the request rules: arithmetic result, retry budget and latency.
    function automatic exp_t ref_model(input logic [2:0] a, b, input logic par, input logic [2:0] op,
                                       input int nfail, input int kind);
        exp_t e;
        int   ia, ib, s;
        bit   ok;
        ia = int'(a);
        ib = int'(b);
        ok = ((op == 3'b001) || (op == 3'b010) || (op == 3'b100)) && ((^{a, b, par}) == 1'b1);
        if (!ok) begin
            e.lat = 1; e.sum = 3'd0; e.cout = 1'b0; e.st = 2'b10; e.fails = 0;
            return e;
        end
        if (op == 3'b001) begin
            s = ia + ib;
            e.cout = (s >= 8);
        end else if (op == 3'b010) begin
            s = ia - ib + 8;
            e.cout = (ia >= ib);
        end else begin
            s = ib - ia + 8;
            e.cout = (ib >= ia);
        end
        e.sum = 3'(s % 8);
        if (nfail > MAX_RETRY) begin
            e.fails = MAX_RETRY + 1;
            e.st    = 2'b11;
            e.lat   = (MAX_RETRY + 1) * (SETTLE + 1) + 1;
            if (kind == 3) e.sum = e.sum ^ 3'b010;
        end else begin
            e.fails = nfail;
            e.st    = (nfail == 0) ? 2'b00 : 2'b01;
            e.lat   = (nfail + 1) * (SETTLE + 1) + 1;
        end
        return e;
    endfunction

    function automatic int sat_add(input int v, input int inc);
        return (v + inc > 255) ? 255 : v + inc;
    endfunction

    // Drives one request from IDLE to consumption and reports what was observed.
    task automatic run_txn(input logic [2:0] a, b, input logic par, input logic [2:0] op,
                           input int nfail, input int kind, input int bp,
                           output int lat, output logic [5:0] rsp, output logic [7:0] err,
                           output bit hs_ok);
        logic [2:0] exp_c;
        hs_ok = 1;
        exp_c = (((op == 3'b001) || (op == 3'b010) || (op == 3'b100)) && ((^{a, b, par}) == 1'b1)) ? op : 3'b000;
        req_a = a; req_b = b; req_par = par; req_op = op; req_valid = 1'b1;
        nfail_cur = nfail; kind_cur = kind;
        @(posedge clk); #1;
        req_valid = 1'b0; fault_en = 1; cur_cyc = 1;
        if (req_ready !== 1'b0 || alu_a !== a || alu_b !== b || alu_par !== par || alu_c !== exp_c) hs_ok = 0;
        lat = -1;
        for (int i = 0; i < 200; i++) begin
            if (rsp_valid === 1'b1) begin
                lat = cur_cyc;
                break;
            end
            if (alu_c !== exp_c || alu_a !== a || alu_b !== b || req_ready !== 1'b0) hs_ok = 0;
            @(posedge clk); #1;
            cur_cyc++;
        end
        fault_en = 0;
        rsp = {rsp_sum, rsp_cout, rsp_status};
        err = err_cnt;
        for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || {rsp_sum, rsp_cout, rsp_status} !== rsp) hs_ok = 0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || alu_c !== 3'b000) hs_ok = 0;
    endtask

    task automatic test_reset();
        logic [25:0] obs;
        rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        req_a = 3'd0; req_b = 3'd0; req_par = 1'b0; req_op = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        obs = {req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_status, alu_a, alu_b, alu_par, alu_c, err_cnt};
        checks++;
        if (obs !== {1'b1, 25'd0}) begin
            failures++;
            $display("FAIL reset_values got=%h want=%h", obs, {1'b1, 25'd0});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_idle got ready=%b valid=%b want ready=1 valid=0", req_ready, rsp_valid);
        end
        err_exp = 0;
        $display("txn reset: ready=%b valid=%b err=%0d", req_ready, rsp_valid, err_cnt);
    endtask

    task automatic test_scenario(input string name, input logic [2:0] a, b, input logic par,
                                 input logic [2:0] op, input int nfail, input int kind, input int bp);
        exp_t       e;
        int         lat;
        logic [5:0] rsp;
        logic [7:0] err;
        bit         hs_ok;
        e = ref_model(a, b, par, op, nfail, kind);
        run_txn(a, b, par, op, nfail, kind, bp, lat, rsp, err, hs_ok);
        err_exp = sat_add(err_exp, e.fails);
        checks++;
        if (lat !== e.lat) begin
            failures++;
            $display("FAIL %s_latency got=%0d want=%0d", name, lat, e.lat);
        end
        checks++;
        if (rsp !== {e.sum, e.cout, e.st}) begin
            failures++;
            $display("FAIL %s_response got sum/cout/st=%h want=%h", name, rsp, {e.sum, e.cout, e.st});
        end
        checks++;
        if (err !== 8'(err_exp)) begin
            failures++;
            $display("FAIL %s_err_cnt got=%0d want=%0d", name, err, err_exp);
        end
        checks++;
        if (!hs_ok) begin
            failures++;
            $display("FAIL %s_handshake got hold/ready violation want none", name);
        end
        $display("txn %s: a=%0d b=%0d op=%b nfail=%0d kind=%0d lat=%0d sum=%0d cout=%b st=%b err=%0d",
                 name, a, b, op, nfail, kind, lat, rsp[5:3], rsp[2], rsp[1:0], err);
    endtask

    task automatic test_clean_add();   test_scenario("clean_add", 3'd3, 3'd2, 1'b0, 3'b001, 0, 0, 0); endtask
    task automatic test_bad_op();      test_scenario("bad_op", 3'd3, 3'd2, 1'b0, 3'b011, 0, 0, 0);    endtask
    task automatic test_transient();   test_scenario("transient", 3'd3, 3'd2, 1'b0, 3'b001, 1, 0, 0); endtask
    task automatic test_persistent();  test_scenario("persistent", 3'd5, 3'd6, 1'b1, 3'b010, 3, 1, 0); endtask
    task automatic test_backpressure(); test_scenario("backpressure", 3'd7, 3'd4, 1'b1, 3'b100, 0, 0, 4); endtask

    task automatic test_random();
        logic [2:0] a, b, op;
        logic       par;
        logic [2:0] onehot [3] = '{3'b001, 3'b010, 3'b100};
        logic [2:0] badop  [5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
        for (int n = 0; n < 40; n++) begin
            a   = 3'($urandom_range(0, 7));
            b   = 3'($urandom_range(0, 7));
            op  = onehot[$urandom_range(0, 2)];
            par = ~(^{a, b});
            case ($urandom_range(0, 9))
                0:       par = ~par;
                1:       op  = badop[$urandom_range(0, 4)];
                default: ;
            endcase
            test_scenario("random", a, b, par, op, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 90; n++)
            test_scenario("saturate", 3'd1, 3'd1, 1'b1, 3'b001, 3, 2, 0);
        test_scenario("saturate_hold", 3'd2, 3'd3, 1'b0, 3'b001, 2, 1, 0);
    endtask

    task automatic test_back_to_back();
        int waited;
        req_a = 3'd1; req_b = 3'd1; req_par = 1'b0; req_op = 3'b001; req_valid = 1'b1;
        @(posedge clk); #1;
        // Invalid parity goes straight to RESP; consume while a valid request is waiting.
        req_par = 1'b1; req_a = 3'd4; req_b = 3'd2; rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || alu_c !== 3'b000) begin
            failures++;
            $display("FAIL b2b_no_accept_on_consume got ready=%b alu_c=%b want ready=1 alu_c=000", req_ready, alu_c);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (alu_c !== 3'b001 || alu_a !== 3'd4 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept_next got alu_c=%b a=%0d ready=%b want 001 4 0", alu_c, alu_a, req_ready);
        end
        waited = 0;
        while (rsp_valid !== 1'b1 && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        checks++;
        if (rsp_valid !== 1'b1 || rsp_sum !== 3'd6 || rsp_status !== 2'b00) begin
            failures++;
            $display("FAIL b2b_result got valid=%b sum=%0d st=%b want 1 6 00", rsp_valid, rsp_sum, rsp_status);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        $display("txn back_to_back: sum=%0d st=%b ready=%b", rsp_sum, rsp_status, req_ready);
    endtask

    task automatic test_reset_mid_retry();
        logic [25:0] obs;
        req_a = 3'd3; req_b = 3'd2; req_par = 1'b0; req_op = 3'b001; req_valid = 1'b1;
        nfail_cur = 3; kind_cur = 1;
        @(posedge clk); #1;
        req_valid = 1'b0; fault_en = 1; cur_cyc = 1;
        repeat (2) begin
            @(posedge clk); #1;
            cur_cyc++;
        end
        checks++;
        if (err_cnt !== 8'(sat_add(err_exp, 1)) || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL midretry_first_fail got err=%0d ready=%b want err=%0d ready=0", err_cnt, req_ready, sat_add(err_exp, 1));
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        fault_en = 0;
        obs = {req_ready, rsp_valid, rsp_sum, rsp_cout, rsp_status, alu_a, alu_b, alu_par, alu_c, err_cnt};
        checks++;
        if (obs !== {1'b1, 25'd0}) begin
            failures++;
            $display("FAIL midretry_reset_values got=%h want=%h", obs, {1'b1, 25'd0});
        end
        rst_n = 1'b1;
        err_exp = 0;
        @(posedge clk); #1;
        $display("txn reset_mid_retry: ready=%b err=%0d", req_ready, err_cnt);
        test_scenario("after_reset", 3'd3, 3'd2, 1'b0, 3'b001, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_clean_add();
        test_bad_op();
        test_transient();
        test_persistent();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_saturation();
        test_reset_mid_retry();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
